ctrl_decode_stage: RTL and testbench
====================================

Name: ctrl_decode_stage

Overview:
Registered successor to the combinational opcode decoder: decodes full RV32I base opcodes into control bundles and holds them in an ID/EX slot with valid/ready handshakes. Sits between fetch/ID and the EX stage.
Detects load-use hazards and inserts one bubble. Handles pipeline flush with a small FSM, and keeps a saturating stall counter for performance monitoring.

Parameters:
ALUOP_W, 4, width of ALU operation code
REG_AW, 5, register index width
FLUSH_CYCLES, 1, cycles in_ready held low after flush (>=1)
CNT_W, 16, stall counter width

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
in_valid  in  1  instr valid from ID
in_ready  out  1  stage accepts instr
instr  in  32  RV32I instruction word
flush  in  1  kill slot contents (branch taken/redirect)
out_valid  out  1  slot holds decoded instr
out_ready  in  1  EX consumes slot
out_reg_write  out  1  write rd
out_mem_read  out  1  load
out_mem_write  out  1  store
out_wb_sel  out  2  0 ALU, 1 MEM, 2 PC+4
out_alu_src_a  out  2  0 rs1, 1 PC, 2 zero
out_alu_src_b  out  1  0 rs2, 1 imm
out_alu_op  out  ALUOP_W  ALU operation
out_branch  out  1  conditional branch
out_jump  out  1  JAL/JALR
out_funct3  out  3  passthrough
out_rd, out_rs1, out_rs2  out  REG_AW  register indices
stall_cnt  out  CNT_W  load-use stall cycles, saturating

Behaviour:
- Reset (async, rst_n=0): all outputs 0; FSM=RUN; stall_cnt=0.
- Fire definitions:
  - in_fire = in_valid & in_ready.
  - out_fire = out_valid & out_ready.
  - Slot loads when in_fire; in_ready requires (!out_valid | out_ready), FSM=RUN, !hz and !flush.
  - Latency: 1 cycle instr->out.
- Decode (by opcode):
  - R (0110011): reg_write, src_b=0.
  - I-ALU (0010011): reg_write, src_b=1.
  - LOAD (0000011): reg_write, mem_read, wb_sel=1, src_b=1, ADD.
  - STORE (0100011): mem_write, src_b=1, ADD.
  - BRANCH (1100011): branch, SUB.
  - JAL (1101111): jump, reg_write, wb_sel=2, src_a=1, src_b=1.
  - JALR (1100111): as JAL but src_a=0.
  - LUI (0110111): reg_write, src_a=2, src_b=1.
  - AUIPC (0010111): reg_write, src_a=1, src_b=1.
  - Others: all ctrl 0, still valid (NOP).
- ALU op from funct3:
  - R type: SUB when funct3=000 and instr[30]=1.
  - I-ALU: SRA when funct3=101 and instr[30]=1; never SUB.
- Source-use flags:
  - uses_rs1: R, I-ALU, LOAD, STORE, BRANCH, JALR.
  - uses_rs2: R, STORE, BRANCH.
- Hazard:
  - hz = in_valid & out_valid & out_mem_read & out_rd!=0 & ((uses_rs1 & rs1==out_rd) | (uses_rs2 & rs2==out_rd)).
  - hz forces in_ready=0.
  - If out_fire in the same cycle, the slot becomes empty (bubble) next cycle; next cycle hz=0 and the instr is accepted.
  - stall_cnt += 1 per hz cycle, saturating at all-ones.
- FSM RUN/FLUSH:
  - flush in RUN: slot cleared next edge (out_valid=0); FSM->FLUSH; load counter FLUSH_CYCLES-1.
  - In FLUSH: in_ready=0; count down; at 0 ->RUN.
  - flush while in FLUSH reloads the counter.
- Simultaneous events:
  - flush overrides in_fire and hz (no stall counted).
  - Unfired slot with out_ready=0 holds all outputs stable.

Optional Feature:
CTRL_ILLEGAL_TRAP_EN:
- Defined: adds outputs out_illegal (1, per-slot) and illegal_seen (1, sticky, cleared only by reset). An unrecognised opcode, or R-type funct7 other than 0000000/0100000, sets out_illegal=1 with all ctrl 0.
- Undefined: ports absent; unknown opcodes decode as NOP.

Decomposition:
- Package ctrl_pkg holds:
  - opcode localparams.
  - ALU op encodings: ADD0 SUB1 SLL2 SLT3 SLTU4 XOR5 SRL6 SRA7 OR8 AND9.
  - wb_sel and src_a encodings.
  - A ctrl bundle struct.
- Sub-module ctrl_decode_comb: pure combinational instr->bundle plus uses_rs1/uses_rs2. The stage adds slot, hazard, FSM and counter.

Test Plan:
- Reset then add x3,x1,x2 (0x002081B3): out_valid=1 next cycle; reg_write=1; alu_op=0; rd=3.
- sub x2,x1,x2 (0x40208133): alu_op=1.
- beq 0x00208063: branch=1, reg_write=0, alu_op=1.
- lw x5,0(x1) (0x0000A283) then add x6,x5,x2 (0x00228333), out_ready=1:
  - in_ready=0 one cycle, out_valid=0 one cycle.
  - add emitted next; stall_cnt=1.
- out_ready=0 for 3 cycles with a valid slot: outputs stable, in_ready=0.
- flush with FLUSH_CYCLES=2 while slot valid:
  - out_valid=0 next cycle; in_ready=0 for 2 cycles.
  - Repeat flush concurrent with hz: no stall counted.
- With CTRL_ILLEGAL_TRAP_EN, instr 0xFFFFFFFF: out_illegal=1, illegal_seen stays 1 until rst_n=0.

Source files
------------

// File: rtl/ctrl_pkg.sv
// ctrl_pkg: shared constants and types for the RV32I decode stage.
//   - RV32I base opcodes
//   - ALU operation encodings (ADD=0 .. AND=9)
//   - write-back select and ALU source-A encodings
//   - ctrl_t: the control bundle carried through the ID/EX slot
//   - alu_from_funct3: maps funct3 (+ instr[30]) onto an ALU operation
package ctrl_pkg;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_IALU   = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    localparam int ALU_OP_W = 4;
    localparam logic [ALU_OP_W-1:0] ALU_ADD  = 4'd0;
    localparam logic [ALU_OP_W-1:0] ALU_SUB  = 4'd1;
    localparam logic [ALU_OP_W-1:0] ALU_SLL  = 4'd2;
    localparam logic [ALU_OP_W-1:0] ALU_SLT  = 4'd3;
    localparam logic [ALU_OP_W-1:0] ALU_SLTU = 4'd4;
    localparam logic [ALU_OP_W-1:0] ALU_XOR  = 4'd5;
    localparam logic [ALU_OP_W-1:0] ALU_SRL  = 4'd6;
    localparam logic [ALU_OP_W-1:0] ALU_SRA  = 4'd7;
    localparam logic [ALU_OP_W-1:0] ALU_OR   = 4'd8;
    localparam logic [ALU_OP_W-1:0] ALU_AND  = 4'd9;

    localparam logic [1:0] WB_ALU = 2'd0;
    localparam logic [1:0] WB_MEM = 2'd1;
    localparam logic [1:0] WB_PC4 = 2'd2;

    localparam logic [1:0] SRC_A_RS1  = 2'd0;
    localparam logic [1:0] SRC_A_PC   = 2'd1;
    localparam logic [1:0] SRC_A_ZERO = 2'd2;

    typedef struct packed {
        logic                reg_write;
        logic                mem_read;
        logic                mem_write;
        logic [1:0]          wb_sel;
        logic [1:0]          alu_src_a;
        logic                alu_src_b;
        logic [ALU_OP_W-1:0] alu_op;
        logic                branch;
        logic                jump;
    } ctrl_t;

    localparam ctrl_t CTRL_NOP = '0;

    // alt is instr[30]; sub_ok is cleared for I-type, where bit 30 is
    // immediate data for ADDI and must not turn it into a subtract.
    function automatic logic [ALU_OP_W-1:0] alu_from_funct3(
        input logic [2:0] f3,
        input logic       alt,
        input logic       sub_ok
    );
        case (f3)
            3'b000:  return (alt && sub_ok) ? ALU_SUB : ALU_ADD;
            3'b001:  return ALU_SLL;
            3'b010:  return ALU_SLT;
            3'b011:  return ALU_SLTU;
            3'b100:  return ALU_XOR;
            3'b101:  return alt ? ALU_SRA : ALU_SRL;
            3'b110:  return ALU_OR;
            default: return ALU_AND;
        endcase
    endfunction

endpackage

// File: rtl/ctrl_decode_comb.sv
// ctrl_decode_comb: purely combinational RV32I instruction -> control bundle.
// Ports:
//   instr      in   32-bit instruction word
//   ctrl       out  decoded control bundle (ctrl_t)
//   uses_rs1   out  instruction reads rs1
//   uses_rs2   out  instruction reads rs2
//   funct3, rd, rs1, rs2  out  field passthrough
//   illegal    out  (only with CTRL_ILLEGAL_TRAP_EN) unknown opcode or bad R funct7
// Optional feature macro: CTRL_ILLEGAL_TRAP_EN.
module ctrl_decode_comb
    import ctrl_pkg::*;
(
    input  logic [31:0] instr,
    output ctrl_t       ctrl,
    output logic        uses_rs1,
    output logic        uses_rs2,
    output logic [2:0]  funct3,
    output logic [4:0]  rd,
    output logic [4:0]  rs1,
    output logic [4:0]  rs2
`ifdef CTRL_ILLEGAL_TRAP_EN
    ,
    output logic        illegal
`endif
);

    logic [6:0] opcode;

    assign opcode = instr[6:0];
    assign funct3 = instr[14:12];
    assign rd     = instr[11:7];
    assign rs1    = instr[19:15];
    assign rs2    = instr[24:20];

`ifdef CTRL_ILLEGAL_TRAP_EN
    assign illegal = !(opcode inside {OP_R, OP_IALU, OP_LOAD, OP_STORE, OP_BRANCH,
                                      OP_JAL, OP_JALR, OP_LUI, OP_AUIPC})
                     || ((opcode == OP_R) && !(instr[31:25] inside {7'b0000000, 7'b0100000}));
`else
    // Only bit 30 of funct7 matters when illegal encodings are not trapped.
    logic unused_funct7;
    assign unused_funct7 = ^{instr[31], instr[29:25]};
`endif

    always_comb begin
        ctrl     = CTRL_NOP;
        uses_rs1 = 1'b0;
        uses_rs2 = 1'b0;
        case (opcode)
            OP_R: begin
                ctrl.reg_write = 1'b1;
                ctrl.alu_op    = alu_from_funct3(funct3, instr[30], 1'b1);
                uses_rs1       = 1'b1;
                uses_rs2       = 1'b1;
            end
            OP_IALU: begin
                ctrl.reg_write = 1'b1;
                ctrl.alu_src_b = 1'b1;
                ctrl.alu_op    = alu_from_funct3(funct3, instr[30], 1'b0);
                uses_rs1       = 1'b1;
            end
            OP_LOAD: begin
                ctrl.reg_write = 1'b1;
                ctrl.mem_read  = 1'b1;
                ctrl.wb_sel    = WB_MEM;
                ctrl.alu_src_b = 1'b1;
                uses_rs1       = 1'b1;
            end
            OP_STORE: begin
                ctrl.mem_write = 1'b1;
                ctrl.alu_src_b = 1'b1;
                uses_rs1       = 1'b1;
                uses_rs2       = 1'b1;
            end
            OP_BRANCH: begin
                ctrl.branch = 1'b1;
                ctrl.alu_op = ALU_SUB;
                uses_rs1    = 1'b1;
                uses_rs2    = 1'b1;
            end
            OP_JAL: begin
                ctrl.jump      = 1'b1;
                ctrl.reg_write = 1'b1;
                ctrl.wb_sel    = WB_PC4;
                ctrl.alu_src_a = SRC_A_PC;
                ctrl.alu_src_b = 1'b1;
            end
            OP_JALR: begin
                ctrl.jump      = 1'b1;
                ctrl.reg_write = 1'b1;
                ctrl.wb_sel    = WB_PC4;
                ctrl.alu_src_a = SRC_A_RS1;
                ctrl.alu_src_b = 1'b1;
                uses_rs1       = 1'b1;
            end
            OP_LUI: begin
                ctrl.reg_write = 1'b1;
                ctrl.alu_src_a = SRC_A_ZERO;
                ctrl.alu_src_b = 1'b1;
            end
            OP_AUIPC: begin
                ctrl.reg_write = 1'b1;
                ctrl.alu_src_a = SRC_A_PC;
                ctrl.alu_src_b = 1'b1;
            end
            default: ;
        endcase
`ifdef CTRL_ILLEGAL_TRAP_EN
        if (illegal) begin
            ctrl = CTRL_NOP;
        end
`endif
    end

endmodule

// File: rtl/ctrl_decode_stage.sv
// ctrl_decode_stage: registered ID/EX slot holding a decoded RV32I control
// bundle, with load-use hazard stall, flush FSM and saturating stall counter.
// Ports:
//   clk, rst_n                 clock (rising edge), async active-low reset
//   in_valid/in_ready, instr   upstream handshake and instruction word
//   flush                      kill slot contents, hold off input for FLUSH_CYCLES
//   out_valid/out_ready        downstream handshake
//   out_*                      decoded control bundle and register fields
//   stall_cnt                  saturating count of load-use stall cycles
//   out_illegal, illegal_seen  (only with CTRL_ILLEGAL_TRAP_EN) per-slot / sticky flags
// Optional feature macro: CTRL_ILLEGAL_TRAP_EN.
module ctrl_decode_stage
    import ctrl_pkg::*;
#(
    parameter int ALUOP_W      = 4,
    parameter int REG_AW       = 5,
    parameter int FLUSH_CYCLES = 1,
    parameter int CNT_W        = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [31:0]        instr,
    input  logic               flush,
    output logic               out_valid,
    input  logic               out_ready,
    output logic               out_reg_write,
    output logic               out_mem_read,
    output logic               out_mem_write,
    output logic [1:0]         out_wb_sel,
    output logic [1:0]         out_alu_src_a,
    output logic               out_alu_src_b,
    output logic [ALUOP_W-1:0] out_alu_op,
    output logic               out_branch,
    output logic               out_jump,
    output logic [2:0]         out_funct3,
    output logic [REG_AW-1:0]  out_rd,
    output logic [REG_AW-1:0]  out_rs1,
    output logic [REG_AW-1:0]  out_rs2,
    output logic [CNT_W-1:0]   stall_cnt
`ifdef CTRL_ILLEGAL_TRAP_EN
    ,
    output logic               out_illegal,
    output logic               illegal_seen
`endif
);

    localparam logic [0:0] ST_RUN   = 1'b0;
    localparam logic [0:0] ST_FLUSH = 1'b1;

    localparam int FC_W = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
    localparam logic [FC_W-1:0] FLUSH_LOAD = FC_W'(FLUSH_CYCLES - 1);

    ctrl_t      dec_ctrl;
    logic       dec_uses_rs1, dec_uses_rs2;
    logic [2:0] dec_funct3;
    logic [4:0] dec_rd, dec_rs1, dec_rs2;

    ctrl_t               ctrl_q, ctrl_d;
    logic                valid_q, valid_d;
    logic [2:0]          funct3_q, funct3_d;
    logic [REG_AW-1:0]   rd_q, rd_d, rs1_q, rs1_d, rs2_q, rs2_d;
    logic [0:0]          state_q, state_d;
    logic [FC_W-1:0]     fcnt_q, fcnt_d;
    logic [CNT_W-1:0]    stall_q, stall_d;
    logic                hz, in_fire, out_fire;

`ifdef CTRL_ILLEGAL_TRAP_EN
    logic dec_illegal;
    logic illegal_q, illegal_d, seen_q, seen_d;
`endif

    ctrl_decode_comb u_decode (
        .instr    (instr),
        .ctrl     (dec_ctrl),
        .uses_rs1 (dec_uses_rs1),
        .uses_rs2 (dec_uses_rs2),
        .funct3   (dec_funct3),
        .rd       (dec_rd),
        .rs1      (dec_rs1),
        .rs2      (dec_rs2)
`ifdef CTRL_ILLEGAL_TRAP_EN
        ,
        .illegal  (dec_illegal)
`endif
    );

    // A load in the slot whose destination is read by the incoming instr
    // must not be bypassed: hold the instr off for one cycle.
    assign hz = in_valid && valid_q && ctrl_q.mem_read && (rd_q != '0)
                && ((dec_uses_rs1 && (REG_AW'(dec_rs1) == rd_q))
                 || (dec_uses_rs2 && (REG_AW'(dec_rs2) == rd_q)));

    assign in_ready = (!valid_q || out_ready) && (state_q == ST_RUN) && !hz && !flush;
    assign in_fire  = in_valid && in_ready;
    assign out_fire = valid_q && out_ready;

    always_comb begin
        ctrl_d   = ctrl_q;
        valid_d  = valid_q;
        funct3_d = funct3_q;
        rd_d     = rd_q;
        rs1_d    = rs1_q;
        rs2_d    = rs2_q;
        state_d  = state_q;
        fcnt_d   = fcnt_q;
        stall_d  = stall_q;
`ifdef CTRL_ILLEGAL_TRAP_EN
        illegal_d = illegal_q;
        seen_d    = seen_q | (in_fire & dec_illegal);
`endif
        if (flush) begin
            // Flush wins over everything, including a pending hazard stall.
            ctrl_d   = CTRL_NOP;
            valid_d  = 1'b0;
            funct3_d = '0;
            rd_d     = '0;
            rs1_d    = '0;
            rs2_d    = '0;
            state_d  = ST_FLUSH;
            fcnt_d   = FLUSH_LOAD;
`ifdef CTRL_ILLEGAL_TRAP_EN
            illegal_d = 1'b0;
`endif
        end else begin
            if (state_q == ST_FLUSH) begin
                if (fcnt_q == '0) begin
                    state_d = ST_RUN;
                end else begin
                    fcnt_d = fcnt_q - 1'b1;
                end
            end
            if (in_fire) begin
                ctrl_d   = dec_ctrl;
                valid_d  = 1'b1;
                funct3_d = dec_funct3;
                rd_d     = REG_AW'(dec_rd);
                rs1_d    = REG_AW'(dec_rs1);
                rs2_d    = REG_AW'(dec_rs2);
`ifdef CTRL_ILLEGAL_TRAP_EN
                illegal_d = dec_illegal;
`endif
            end else if (out_fire) begin
                valid_d = 1'b0;
            end
            if (hz && (stall_q != {CNT_W{1'b1}})) begin
                stall_d = stall_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ctrl_q   <= CTRL_NOP;
            valid_q  <= 1'b0;
            funct3_q <= '0;
            rd_q     <= '0;
            rs1_q    <= '0;
            rs2_q    <= '0;
            state_q  <= ST_RUN;
            fcnt_q   <= '0;
            stall_q  <= '0;
`ifdef CTRL_ILLEGAL_TRAP_EN
            illegal_q <= 1'b0;
            seen_q    <= 1'b0;
`endif
        end else begin
            ctrl_q   <= ctrl_d;
            valid_q  <= valid_d;
            funct3_q <= funct3_d;
            rd_q     <= rd_d;
            rs1_q    <= rs1_d;
            rs2_q    <= rs2_d;
            state_q  <= state_d;
            fcnt_q   <= fcnt_d;
            stall_q  <= stall_d;
`ifdef CTRL_ILLEGAL_TRAP_EN
            illegal_q <= illegal_d;
            seen_q    <= seen_d;
`endif
        end
    end

    assign out_valid     = valid_q;
    assign out_reg_write = ctrl_q.reg_write;
    assign out_mem_read  = ctrl_q.mem_read;
    assign out_mem_write = ctrl_q.mem_write;
    assign out_wb_sel    = ctrl_q.wb_sel;
    assign out_alu_src_a = ctrl_q.alu_src_a;
    assign out_alu_src_b = ctrl_q.alu_src_b;
    assign out_alu_op    = ALUOP_W'(ctrl_q.alu_op);
    assign out_branch    = ctrl_q.branch;
    assign out_jump      = ctrl_q.jump;
    assign out_funct3    = funct3_q;
    assign out_rd        = rd_q;
    assign out_rs1       = rs1_q;
    assign out_rs2       = rs2_q;
    assign stall_cnt     = stall_q;
`ifdef CTRL_ILLEGAL_TRAP_EN
    assign out_illegal   = illegal_q;
    assign illegal_seen  = seen_q;
`endif

endmodule

// File: tb/tb_ctrl_decode_stage.sv
// Scoreboard bench for ctrl_decode_stage: a driver issues directed then
// random instructions and pushes the reference decode of every accepted
// instr into a queue; a monitor on the falling edge compares the slot,
// in_ready and stall counter against the reference model.
module tb_ctrl_decode_stage;

    localparam int FC = 2;
    localparam int CW = 3;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        in_valid = 1'b0;
    logic        flush = 1'b0;
    logic        out_ready = 1'b0;
    logic [31:0] instr = '0;

    logic        in_ready, out_valid;
    logic        out_reg_write, out_mem_read, out_mem_write, out_alu_src_b;
    logic        out_branch, out_jump;
    logic [1:0]  out_wb_sel, out_alu_src_a;
    logic [3:0]  out_alu_op;
    logic [2:0]  out_funct3;
    logic [4:0]  out_rd, out_rs1, out_rs2;
    logic [CW-1:0] stall_cnt;
`ifdef CTRL_ILLEGAL_TRAP_EN
    logic        out_illegal, illegal_seen;
`endif

    always #5 clk = ~clk;

    ctrl_decode_stage #(
        .ALUOP_W(4), .REG_AW(5), .FLUSH_CYCLES(FC), .CNT_W(CW)
    ) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .instr(instr), .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
        .out_reg_write(out_reg_write), .out_mem_read(out_mem_read),
        .out_mem_write(out_mem_write), .out_wb_sel(out_wb_sel),
        .out_alu_src_a(out_alu_src_a), .out_alu_src_b(out_alu_src_b),
        .out_alu_op(out_alu_op), .out_branch(out_branch), .out_jump(out_jump),
        .out_funct3(out_funct3), .out_rd(out_rd), .out_rs1(out_rs1),
        .out_rs2(out_rs2), .stall_cnt(stall_cnt)
`ifdef CTRL_ILLEGAL_TRAP_EN
        , .out_illegal(out_illegal), .illegal_seen(illegal_seen)
`endif
    );

    typedef struct packed {
        logic       ill;
        logic       rw;
        logic       mr;
        logic       mw;
        logic [1:0] wb;
        logic [1:0] sa;
        logic       sb;
        logic [3:0] alu;
        logic       br;
        logic       jp;
        logic [2:0] f3;
        logic [4:0] rd;
        logic [4:0] rs1;
        logic [4:0] rs2;
    } exp_t;

    exp_t q[$];
    int   compared = 0;
    int   mismatched = 0;
    int   flush_left = 0;
    int   stall_exp = 0;
    int   txn = 0;
    bit   illegal_seen_exp = 1'b0;
    bit   accept_m = 1'b0;

    // Reference decode, straight from the opcode table.
    function automatic exp_t model(input logic [31:0] w);
        exp_t e;
        int   tbl[8];
        logic [6:0] op;
        logic [2:0] f3;
        logic [6:0] f7;
        tbl = '{0, 2, 3, 4, 5, 6, 8, 9};  // ADD SLL SLT SLTU XOR SRL OR AND
        op = w[6:0];
        f3 = w[14:12];
        f7 = w[31:25];
        e = '0;
        e.f3 = f3; e.rd = w[11:7]; e.rs1 = w[19:15]; e.rs2 = w[24:20];
        case (op)
            7'h33: begin
                e.rw = 1; e.alu = 4'(tbl[f3]);
                if (w[30] && f3 == 3'd0) e.alu = 4'd1;
                if (w[30] && f3 == 3'd5) e.alu = 4'd7;
`ifdef CTRL_ILLEGAL_TRAP_EN
                if (f7 != 7'h00 && f7 != 7'h20) begin
                    e.rw = 0; e.alu = 0; e.ill = 1;
                end
`endif
            end
            7'h13: begin
                e.rw = 1; e.sb = 1; e.alu = 4'(tbl[f3]);
                if (w[30] && f3 == 3'd5) e.alu = 4'd7;
            end
            7'h03: begin e.rw = 1; e.mr = 1; e.wb = 2'd1; e.sb = 1; end
            7'h23: begin e.mw = 1; e.sb = 1; end
            7'h63: begin e.br = 1; e.alu = 4'd1; end
            7'h6F: begin e.jp = 1; e.rw = 1; e.wb = 2'd2; e.sa = 2'd1; e.sb = 1; end
            7'h67: begin e.jp = 1; e.rw = 1; e.wb = 2'd2; e.sa = 2'd0; e.sb = 1; end
            7'h37: begin e.rw = 1; e.sa = 2'd2; e.sb = 1; end
            7'h17: begin e.rw = 1; e.sa = 2'd1; e.sb = 1; end
            default: begin
`ifdef CTRL_ILLEGAL_TRAP_EN
                e.ill = 1;
`endif
            end
        endcase
        if (f7 == 7'h7F && op == 7'h7F) e.ill = e.ill;  // no-op: keeps f7 referenced in all builds
        return e;
    endfunction

    function automatic bit reads_rs1(input logic [6:0] op);
        return op inside {7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h67};
    endfunction

    function automatic bit reads_rs2(input logic [6:0] op);
        return op inside {7'h33, 7'h23, 7'h63};
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        compared++;
        if (act !== req) begin
            mismatched++;
            $display("FAIL %s: actual=%h required=%h (t=%0t)", name, act, req, $time);
        end
    endtask

    // Monitor: compare DUT state against the model, then advance the model.
    always @(negedge clk) begin
        exp_t a;
        bit   exp_v, hz, exp_ir;
        a = '{ill: 1'b0, rw: out_reg_write, mr: out_mem_read, mw: out_mem_write,
              wb: out_wb_sel, sa: out_alu_src_a, sb: out_alu_src_b, alu: out_alu_op,
              br: out_branch, jp: out_jump, f3: out_funct3, rd: out_rd,
              rs1: out_rs1, rs2: out_rs2};
`ifdef CTRL_ILLEGAL_TRAP_EN
        a.ill = out_illegal;
`endif
        if (!rst_n) begin
            check("rst_out_valid", 64'(out_valid), 64'd0);
            check("rst_stall_cnt", 64'(stall_cnt), 64'd0);
            check("rst_slot", 64'(a), 64'd0);
`ifdef CTRL_ILLEGAL_TRAP_EN
            check("rst_illegal_seen", 64'(illegal_seen), 64'd0);
`endif
            q.delete();
            flush_left = 0;
            stall_exp = 0;
            illegal_seen_exp = 1'b0;
            accept_m = 1'b0;
        end else begin
            exp_v = (q.size() > 0);
            check("out_valid", 64'(out_valid), 64'(exp_v));
            if (exp_v && out_valid) begin
                check("slot", 64'(a), 64'(q[0]));
            end
            check("stall_cnt", 64'(stall_cnt), 64'(stall_exp));
`ifdef CTRL_ILLEGAL_TRAP_EN
            check("illegal_seen", 64'(illegal_seen), 64'(illegal_seen_exp));
`endif
            hz = 1'b0;
            if (in_valid && exp_v && q[0].mr && q[0].rd != 5'd0) begin
                hz = (reads_rs1(instr[6:0]) && instr[19:15] == q[0].rd)
                  || (reads_rs2(instr[6:0]) && instr[24:20] == q[0].rd);
            end
            exp_ir = (!exp_v || out_ready) && (flush_left == 0) && !hz && !flush;
            check("in_ready", 64'(in_ready), 64'(exp_ir));
            accept_m = in_valid && exp_ir;

            if (flush) flush_left = FC;
            else if (flush_left > 0) flush_left--;
            if (hz && !flush && stall_exp < (1 << CW) - 1) stall_exp++;
            if (!flush && exp_v && out_ready) begin
                txn++;
                $display("txn %0d: slot emitted %h", txn, q[0]);
                void'(q.pop_front());
            end
        end
    end

    // Driver: one call = one clock cycle of stimulus.
    task automatic cyc(input bit r, input bit v, input logic [31:0] w,
                       input bit fl, input bit ordy);
        exp_t e;
        @(posedge clk);
        #1;
        rst_n = r; in_valid = v; instr = w; flush = fl; out_ready = ordy;
        @(negedge clk);
        #1;
        if (rst_n) begin
            if (flush) begin
                q.delete();
            end else if (accept_m) begin
                e = model(w);
                q.push_back(e);
                if (e.ill) illegal_seen_exp = 1'b1;
            end
        end
    endtask

    function automatic logic [31:0] rand_instr();
        logic [6:0] ops[10];
        logic [6:0] op, f7;
        ops = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h6F, 7'h67, 7'h37, 7'h17, 7'h00};
        op = ops[$urandom_range(0, 9)];
        if (op == 7'h00) op = 7'($urandom);
        if ($urandom_range(0, 7) == 0) f7 = 7'($urandom);
        else f7 = $urandom_range(0, 1) ? 7'h20 : 7'h00;
        return {f7, 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                3'($urandom), 5'($urandom_range(0, 3)), op};
    endfunction

    localparam logic [31:0] I_ADD  = 32'h002081B3;
    localparam logic [31:0] I_SUB  = 32'h40208133;
    localparam logic [31:0] I_BEQ  = 32'h00208063;
    localparam logic [31:0] I_LW   = 32'h0000A283;
    localparam logic [31:0] I_ADD2 = 32'h00228333;

    initial begin
        #1 rst_n = 1'b0;
        repeat (3) cyc(0, 0, '0, 0, 0);
        cyc(1, 1, I_ADD, 0, 1);
        cyc(1, 1, I_SUB, 0, 1);
        cyc(1, 1, I_BEQ, 0, 1);
        cyc(1, 1, I_LW, 0, 1);
        cyc(1, 1, I_ADD2, 0, 1);                     // load-use: stalled, slot drains
        cyc(1, 1, I_ADD2, 0, 0);                     // accepted after the bubble
        repeat (3) cyc(1, 1, I_ADD, 0, 0);           // EX back-pressure: slot held
        cyc(1, 1, I_ADD, 1, 0);                      // flush a valid slot
        repeat (3) cyc(1, 1, I_ADD, 0, 1);
        cyc(1, 1, I_LW, 0, 1);
        cyc(1, 1, I_ADD2, 1, 1);                     // flush together with a hazard
        repeat (3) cyc(1, 0, '0, 0, 1);
        cyc(1, 1, 32'hFFFF_FFFF, 0, 1);              // unknown opcode
        repeat (4) cyc(1, 0, '0, 0, 0);
        for (int i = 0; i < 3000; i++) begin
            if (i == 1500) begin
                cyc(0, 0, '0, 0, 0);
                cyc(0, 0, '0, 0, 0);
            end else begin
                cyc(1, ($urandom_range(0, 9) < 7), rand_instr(),
                    ($urandom_range(0, 19) == 0), ($urandom_range(0, 9) < 7));
            end
        end
        cyc(1, 0, '0, 0, 1);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
